// File: rtl/img_mem_pkg.sv
// Shared constants and small helpers for the image memory arbiter.
package img_mem_pkg;

  localparam int NREQ     = 3;
  localparam int ROW_W    = 8;
  localparam int COL_W    = 9;
  localparam int DATA_W   = 8;
  localparam int unsigned IMG_ROWS = 256;
  localparam int unsigned IMG_COLS = 320;
  localparam int MAX_LOCK = 16;

  localparam int IDX_W    = $clog2(NREQ);
  localparam int LCNT_W   = $clog2(MAX_LOCK + 1);

  localparam logic [IDX_W-1:0] REQ_LOAD = 2'd0;
  localparam logic [IDX_W-1:0] REQ_CONV = 2'd1;
  localparam logic [IDX_W-1:0] REQ_READ = 2'd2;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : idx + {{(IDX_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic addr_oob(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return (32'(r) >= IMG_ROWS) || (32'(c) >= IMG_COLS);
  endfunction

endpackage

// File: rtl/img_mem_arbiter_arb_pick.sv
// One-hot winner search starting at a given index; start tied to 0 gives fixed priority.
module arb_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rot_s;
  logic [N-1:0] pick_s;

  // Rotate so 'start' lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_s  = N'({req, req} >> start);
    pick_s = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
    gnt    = N'(({pick_s, pick_s} << start) >> N);
  end

endmodule

// File: rtl/img_mem_arbiter.sv
// Image memory port arbiter: 0-cycle grant, lockable bursts, range check, 2-cycle read return.
// Build option ARB_RR_EN selects round-robin; without it the loader has fixed top priority.
module img_mem_arbiter
  import img_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ROW_W-1:0]  row,
  input  logic [NREQ*COL_W-1:0]  col,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   addr_err,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ROW_W-1:0]       mem_row,
  output logic [COL_W-1:0]       mem_col,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  logic              owner_vld_r;
  logic [IDX_W-1:0]  owner_idx_r;
  logic [LCNT_W-1:0] lock_cnt_r;
  logic [IDX_W-1:0]  start_s;
  logic [NREQ-1:0]   pick_gnt_s;
  logic [NREQ-1:0]   owner_oh_s;
  logic [NREQ-1:0]   gnt_s;
  logic              lock_hold_s;
  logic              gnt_any_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              sel_we_s;
  logic [ROW_W-1:0]  sel_row_s;
  logic [COL_W-1:0]  sel_col_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              oob_s;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ROW_W-1:0]  mem_row_r;
  logic [COL_W-1:0]  mem_col_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              addr_err_r;

  logic              rd_vld1_r;
  logic              rd_oob1_r;
  logic [IDX_W-1:0]  rd_tag1_r;
  logic              rd_vld2_r;
  logic              rd_oob2_r;
  logic [IDX_W-1:0]  rd_tag2_r;

`ifdef ARB_RR_EN
  logic [IDX_W-1:0]  rr_ptr_r;

  // Search pointer moves past each freely arbitrated winner; locked re-grants leave it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= {IDX_W{1'b0}};
    end else if (gnt_any_s && !lock_hold_s) begin
      rr_ptr_r <= next_idx(gnt_idx_s);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign start_s = rr_ptr_r;
`else
  assign start_s = {IDX_W{1'b0}};
`endif

  arb_pick #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_pick (
    .req   (req),
    .start (start_s),
    .gnt   (pick_gnt_s)
  );

  assign owner_oh_s  = idx_to_onehot(owner_idx_r);
  assign lock_hold_s = owner_vld_r && (|(req & lock & owner_oh_s)) &&
                       (lock_cnt_r < LCNT_W'(MAX_LOCK));

  // Grant: locked owner keeps the port, otherwise the picker decides; nothing during reset.
  always_comb begin
    gnt_s = {NREQ{1'b0}};
    if (reset) begin
      gnt_s = {NREQ{1'b0}};
    end else if (lock_hold_s) begin
      gnt_s = owner_oh_s;
    end else begin
      gnt_s = pick_gnt_s;
    end
  end

  assign gnt       = gnt_s;
  assign gnt_any_s = |gnt_s;
  assign gnt_idx_s = onehot_to_idx(gnt_s);

  // Route the winner's command fields; gnt_s is one-hot so an AND-OR mux suffices.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_row_s   = {ROW_W{1'b0}};
    sel_col_s   = {COL_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_we_s    = sel_we_s    | (we[i] & gnt_s[i]);
      sel_row_s   = sel_row_s   | (row[i*ROW_W +: ROW_W]     & {ROW_W{gnt_s[i]}});
      sel_col_s   = sel_col_s   | (col[i*COL_W +: COL_W]     & {COL_W{gnt_s[i]}});
      sel_wdata_s = sel_wdata_s | (wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
    end
  end

  assign oob_s = addr_oob(sel_row_s, sel_col_s);

  // Ownership and lock run length; the first grant of a run counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_vld_r <= 1'b0;
      owner_idx_r <= {IDX_W{1'b0}};
      lock_cnt_r  <= {LCNT_W{1'b0}};
    end else if (gnt_any_s) begin
      owner_vld_r <= 1'b1;
      owner_idx_r <= gnt_idx_s;
      lock_cnt_r  <= lock_hold_s ? lock_cnt_r + {{(LCNT_W-1){1'b0}}, 1'b1}
                                 : {{(LCNT_W-1){1'b0}}, 1'b1};
    end else begin
      owner_vld_r <= 1'b0;
      owner_idx_r <= owner_idx_r;
      lock_cnt_r  <= {LCNT_W{1'b0}};
    end
  end

  // Memory command stage; an out-of-range access is suppressed and flagged instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_row_r   <= {ROW_W{1'b0}};
      mem_col_r   <= {COL_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      addr_err_r  <= 1'b0;
    end else begin
      mem_en_r   <= gnt_any_s & ~oob_s;
      mem_we_r   <= gnt_any_s & ~oob_s & sel_we_s;
      addr_err_r <= gnt_any_s & oob_s;
      if (gnt_any_s) begin
        mem_row_r   <= sel_row_s;
        mem_col_r   <= sel_col_s;
        mem_wdata_r <= sel_wdata_s;
      end else begin
        mem_row_r   <= mem_row_r;
        mem_col_r   <= mem_col_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  // Two-stage read tag pipe aligned with the memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld1_r <= 1'b0;
      rd_oob1_r <= 1'b0;
      rd_tag1_r <= {IDX_W{1'b0}};
      rd_vld2_r <= 1'b0;
      rd_oob2_r <= 1'b0;
      rd_tag2_r <= {IDX_W{1'b0}};
    end else begin
      rd_vld1_r <= gnt_any_s & ~sel_we_s;
      rd_oob1_r <= oob_s;
      rd_tag1_r <= gnt_idx_s;
      rd_vld2_r <= rd_vld1_r;
      rd_oob2_r <= rd_oob1_r;
      rd_tag2_r <= rd_tag1_r;
    end
  end

  assign rvalid    = rd_vld2_r ? idx_to_onehot(rd_tag2_r) : {NREQ{1'b0}};
  assign rdata     = (rd_vld2_r && !rd_oob2_r) ? mem_rdata : {DATA_W{1'b0}};
  assign addr_err  = addr_err_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_row   = mem_row_r;
  assign mem_col   = mem_col_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed self-checking bench for img_mem_arbiter with a behavioural synchronous image memory.
module tb_img_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, lock, we;
  logic [23:0] row;
  logic [26:0] col;
  logic [23:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata;
  logic        addr_err, mem_en, mem_we;
  logic [7:0]  mem_row;
  logic [8:0]  mem_col;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  img_mem [0:255][0:319];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  img_mem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .row(row), .col(col), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .addr_err(addr_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) img_mem[mem_row][mem_col] <= mem_wdata;
      else        mem_rdata <= img_mem[mem_row][mem_col];
    end
  end

  task automatic idle_all();
    req = 3'b000; lock = 3'b000; we = 3'b000;
  endtask

  task automatic set_req(input int i, input logic w, input logic l,
                         input logic [7:0] r, input logic [8:0] c, input logic [7:0] d);
    req[i] = 1'b1; we[i] = w; lock[i] = l;
    row[i*8 +: 8] = r; col[i*9 +: 9] = c; wdata[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; idle_all();
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; req = 3'b111;
    #1; n_vec++;
    if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt_held: got %b exp 000", gnt); end
    @(negedge clk); reset = 1'b0; idle_all();
    #1; n_vec++;
    if ({gnt, rvalid, rdata, addr_err, mem_en, mem_we} !== 16'h0000) begin
      n_err++; $display("FAIL rst_ctrl: gnt %b rvalid %b rdata %h err %b en %b we %b exp all 0",
                        gnt, rvalid, rdata, addr_err, mem_en, mem_we);
    end
    n_vec++;
    if ({mem_row, mem_col, mem_wdata} !== 25'h0) begin
      n_err++; $display("FAIL rst_mem_bus: row %h col %h wdata %h exp 0", mem_row, mem_col, mem_wdata);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk); set_req(0, 1'b1, 1'b0, 8'd5, 9'd7, 8'h3C);
    #1; n_vec++;
    if (gnt !== 3'b001) begin n_err++; $display("FAIL preload_gnt: got %b exp 001", gnt); end
    @(negedge clk); idle_all();
    n_vec++;
    if ({mem_en, mem_we, mem_row, mem_col, mem_wdata} !== {1'b1, 1'b1, 8'd5, 9'd7, 8'h3C}) begin
      n_err++; $display("FAIL preload_cmd: en %b we %b row %0d col %0d wd %h exp 1 1 5 7 3c",
                        mem_en, mem_we, mem_row, mem_col, mem_wdata);
    end
    @(negedge clk); set_req(1, 1'b0, 1'b0, 8'd5, 9'd7, 8'h00);
    n_vec++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL write_no_rvalid: got %b exp 000", rvalid); end
    #1; n_vec++;
    if (gnt !== 3'b010) begin n_err++; $display("FAIL rd1_gnt: got %b exp 010", gnt); end
    @(negedge clk); idle_all();
    n_vec++;
    if ({mem_en, mem_we} !== 2'b10) begin
      n_err++; $display("FAIL rd1_cmd: en %b we %b exp 1 0", mem_en, mem_we);
    end
    @(negedge clk);
    n_vec++;
    if (rvalid !== 3'b010 || rdata !== 8'h3C) begin
      n_err++; $display("FAIL rd1_data: rvalid %b rdata %h exp 010 3c", rvalid, rdata);
    end
    @(negedge clk);
    n_vec++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL rd1_single: got %b exp 000", rvalid); end
  endtask

  task automatic test_write_read();
    @(negedge clk); set_req(0, 1'b1, 1'b0, 8'd10, 9'd20, 8'hA5);
    #1; n_vec++;
    if (gnt !== 3'b001) begin n_err++; $display("FAIL wr_gnt: got %b exp 001", gnt); end
    @(negedge clk); idle_all(); set_req(2, 1'b0, 1'b0, 8'd10, 9'd20, 8'h00);
    #1; n_vec++;
    if (gnt !== 3'b100) begin n_err++; $display("FAIL rd2_gnt: got %b exp 100", gnt); end
    @(negedge clk); idle_all();
    n_vec++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL wr_no_rvalid: got %b exp 000", rvalid); end
    @(negedge clk);
    n_vec++;
    if (rvalid !== 3'b100 || rdata !== 8'hA5) begin
      n_err++; $display("FAIL rd2_data: rvalid %b rdata %h exp 100 a5", rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_req(1, 1'b0, 1'b0, 8'd5, 9'd7, 8'h00);
    @(negedge clk); idle_all(); set_req(2, 1'b0, 1'b0, 8'd10, 9'd20, 8'h00);
    @(negedge clk); idle_all();
    n_vec++;
    if (rvalid !== 3'b010 || rdata !== 8'h3C) begin
      n_err++; $display("FAIL b2b_first: rvalid %b rdata %h exp 010 3c", rvalid, rdata);
    end
    @(negedge clk);
    n_vec++;
    if (rvalid !== 3'b100 || rdata !== 8'hA5) begin
      n_err++; $display("FAIL b2b_second: rvalid %b rdata %h exp 100 a5", rvalid, rdata);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_g;
    do_reset();
    set_req(0, 1'b0, 1'b0, 8'd0, 9'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'd1, 9'd1, 8'h00);
    set_req(2, 1'b0, 1'b0, 8'd2, 9'd2, 8'h00);
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_RR_EN
      exp_g = 3'b001 << (k % 3);
`else
      exp_g = 3'b001;
`endif
      #1; n_vec++;
      if (gnt !== exp_g) begin n_err++; $display("FAIL rotate_c%0d: got %b exp %b", k, gnt, exp_g); end
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic test_lock();
    logic [2:0] exp_g;
    do_reset();
    set_req(1, 1'b0, 1'b1, 8'd3, 9'd3, 8'h00);
    for (int k = 0; k < 19; k++) begin
      if (k == 1) begin
        set_req(0, 1'b0, 1'b0, 8'd0, 9'd0, 8'h00);
        set_req(2, 1'b0, 1'b0, 8'd2, 9'd2, 8'h00);
      end
`ifdef ARB_RR_EN
      exp_g = (k < 16) ? 3'b010 : (k == 16) ? 3'b100 : (k == 17) ? 3'b001 : 3'b010;
`else
      if (k == 17) req[0] = 1'b0;
      exp_g = (k < 16) ? 3'b010 : (k == 16) ? 3'b001 : 3'b010;
`endif
      #1; n_vec++;
      if (gnt !== exp_g) begin n_err++; $display("FAIL lock_c%0d: got %b exp %b", k, gnt, exp_g); end
      @(negedge clk);
    end
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_range();
    @(negedge clk); set_req(2, 1'b0, 1'b0, 8'd255, 9'd319, 8'h00);
    @(negedge clk); idle_all();
    n_vec++;
    if (mem_en !== 1'b1 || addr_err !== 1'b0) begin
      n_err++; $display("FAIL edge_in_range: en %b err %b exp 1 0", mem_en, addr_err);
    end
    set_req(1, 1'b0, 1'b0, 8'd10, 9'd20, 8'h00);
    @(negedge clk); idle_all(); set_req(2, 1'b0, 1'b0, 8'd0, 9'd320, 8'h00);
    #1; n_vec++;
    if (gnt !== 3'b100) begin n_err++; $display("FAIL oob_gnt: got %b exp 100", gnt); end
    @(negedge clk); idle_all();
    n_vec++;
    if (mem_en !== 1'b0 || addr_err !== 1'b1) begin
      n_err++; $display("FAIL oob_cmd: en %b err %b exp 0 1", mem_en, addr_err);
    end
    @(negedge clk);
    n_vec++;
    if (addr_err !== 1'b0 || rvalid !== 3'b100 || rdata !== 8'h00) begin
      n_err++; $display("FAIL oob_rd: err %b rvalid %b rdata %h exp 0 100 00", addr_err, rvalid, rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); set_req(1, 1'b0, 1'b0, 8'd5, 9'd7, 8'h00);
    #1; n_vec++;
    if (gnt !== 3'b010) begin n_err++; $display("FAIL mid_gnt: got %b exp 010", gnt); end
    @(negedge clk); idle_all(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_vec++;
    if ({gnt, rvalid, rdata, addr_err, mem_en, mem_we, mem_row, mem_col, mem_wdata} !== 41'h0) begin
      n_err++; $display("FAIL mid_outputs: gnt %b rvalid %b rdata %h en %b row %h col %h exp all 0",
                        gnt, rvalid, rdata, mem_en, mem_row, mem_col);
    end
    @(negedge clk);
    n_vec++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL mid_no_rvalid: got %b exp 000", rvalid); end
  endtask

  initial begin
    reset = 1'b1; idle_all(); row = 24'h0; col = 27'h0; wdata = 24'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_write_read();
    test_back_to_back();
    test_rotation();
    test_lock();
    test_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img_mem_arbiter.md
# img_mem_arbiter

Shares the single synchronous port of the image memory between three requesters: the host pixel loader (writes), the convolution window fetcher (reads), and the result readback path (reads). One access per clock, with one-cycle grant, a lock for uninterrupted 3x3 window bursts, and address range checking. It sits between the pixel controllers and the image memory in the top-level image-processing datapath.

## Interface
- NREQ, 3, number of requesters; index 0 = loader, 1 = conv fetch, 2 = readback
- ROW_W, 8, row address width
- COL_W, 9, column address width
- DATA_W, 8, pixel width
- IMG_ROWS, 256, valid rows (0..IMG_ROWS-1)
- IMG_COLS, 320, valid columns (0..IMG_COLS-1)
- MAX_LOCK, 16, maximum consecutive locked grants to one requester
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester access request
- lock  in  NREQ  keep grant after the current access
- we  in  NREQ  1 = write, 0 = read
- row  in  NREQ*ROW_W  flattened row addresses, requester i at [i*ROW_W +: ROW_W]
- col  in  NREQ*COL_W  flattened column addresses
- wdata  in  NREQ*DATA_W  flattened write data
- gnt  out  NREQ  one-hot grant, combinational
- rvalid  out  NREQ  read data valid for requester i
- rdata  out  DATA_W  read data, shared by all requesters, qualified by rvalid
- addr_err  out  1  one-cycle pulse on an out-of-range access
- mem_en, mem_we  out  1 each  memory command, registered
- mem_row  out  ROW_W  registered
- mem_col  out  COL_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency

## Operation
- Transfer happens in cycle N when req[i] & gnt[i]. The requester holds req, we, and address/data stable until granted. It may drop req without a grant (withdraw).
- At most one gnt bit is high. gnt is 0 when req is 0.
- Lock: if the current owner granted in N-1 has req & lock high in N, it is granted again in N regardless of others. The lock counter increments per locked grant. At MAX_LOCK the lock is ignored for one arbitration, so others win if requesting.
- Range check: row >= IMG_ROWS or col >= IMG_COLS.
  - The access is still granted, but mem_en stays 0 and addr_err pulses at N+1.
  - A read still produces rvalid with rdata = 0.
- Writes produce no rvalid.
- Read pipeline: grant at N -> mem_* valid at N+1 -> mem_rdata at N+2. rvalid[i] = 1 and rdata = mem_rdata during N+2. The tag of the owning requester is carried in a 2-stage shift register.
- Back-to-back reads from different requesters return in grant order, one per cycle.
- Reset values: gnt 0, rvalid 0, rdata 0, addr_err 0, mem_en 0, mem_we 0, mem_row/col/wdata 0, RR pointer 0, lock counter 0, owner none.
- Reset mid-operation clears in-flight read tags; no rvalid is issued for accesses granted before reset.

## Timing
- Grant latency: 0 cycles (same cycle as req) when the requester wins.
- Read latency: 2 cycles from grant to rvalid.
- Write commit: memory write at edge ending N+1.
- Throughput: 1 access/cycle sustained.
- Worst-case wait, round-robin, no locks: NREQ-1 cycles. With locks: (NREQ-1)*MAX_LOCK cycles.

## Configuration
- ARB_RR_EN defined: round-robin. The search starts at (last granted index + 1) mod NREQ, and the pointer updates on every unlocked grant.
- ARB_RR_EN undefined: fixed priority, lowest index wins. The loader has highest priority. The RR pointer is not built. Lock and MAX_LOCK behave identically in both modes.

## Structure
- Shared package img_mem_pkg:
  - ROW_W, COL_W, DATA_W, IMG_ROWS, IMG_COLS
  - requester index constants REQ_LOAD=0, REQ_CONV=1, REQ_READ=2
- Sub-module arb_pick: request vector plus start index -> one-hot winner. Round-robin via double-width rotate. Fixed priority is the start index tied to 0.

## Test plan
- Single read by requester 1 at (5,7), memory preloaded with 0x3C: gnt[1] same cycle, rvalid[1] two cycles later, rdata=0x3C.
- Requester 0 writes 0xA5 to (10,20), then requester 2 reads (10,20) the next cycle -> rvalid[2] with 0xA5.
- All three requesting continuously, ARB_RR_EN defined: grants rotate 0,1,2,0,… After the idle reset pointer, the first grant goes to 0. Without the macro, requester 0 is granted every cycle.
- Requester 1 holds lock with req for 20 cycles while 0 and 2 request:
  - 16 consecutive grants to 1, then one grant to another requester.
  - 1 regains the grant when next eligible.
- Read of (0,320) by requester 2: mem_en stays 0, addr_err pulses, rvalid[2] with rdata=0.
- Reset asserted one cycle after a read grant: no rvalid afterwards, all outputs at reset values the next cycle.
